// File: rtl/alu_issue_pkg.sv
// Shared constants for the alu_issue slice: opcodes, R-type functs, ALU operation codes and FSM states.
package alu_issue_pkg;

  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_BEQ   = 6'h04;
  localparam logic [5:0] OPC_BNE   = 6'h05;
  localparam logic [5:0] OPC_ADDI  = 6'h08;
  localparam logic [5:0] OPC_SLTI  = 6'h0a;
  localparam logic [5:0] OPC_ANDI  = 6'h0c;
  localparam logic [5:0] OPC_ORI   = 6'h0d;
  localparam logic [5:0] OPC_MULI  = 6'h1d;

  localparam logic [5:0] FN_SLL = 6'h01;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2a;
  localparam logic [5:0] FN_MUL = 6'h2c;

  localparam logic [5:0] OPRN_NOP = 6'h00;
  localparam logic [5:0] OPRN_ADD = 6'h01;
  localparam logic [5:0] OPRN_SUB = 6'h02;
  localparam logic [5:0] OPRN_MUL = 6'h03;
  localparam logic [5:0] OPRN_SRL = 6'h04;
  localparam logic [5:0] OPRN_SLL = 6'h05;
  localparam logic [5:0] OPRN_AND = 6'h06;
  localparam logic [5:0] OPRN_OR  = 6'h07;
  localparam logic [5:0] OPRN_NOR = 6'h08;
  localparam logic [5:0] OPRN_SLT = 6'h09;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/alu_issue_decode.sv
// Combinational instruction decoder for alu_issue: opcode/funct to ALU operation and operand pair.
// ALU_ISSUE_BRANCH_EN enables beq/bne decoding (as sub); otherwise those opcodes are unsupported.
module alu_issue_decode
  import alu_issue_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int OPRN_WIDTH = 6
) (
  input  logic [31:0]           instr_i,
  input  logic [DATA_WIDTH-1:0] rs_data_i,
  input  logic [DATA_WIDTH-1:0] rt_data_i,
  output logic [OPRN_WIDTH-1:0] oprn_o,
  output logic [DATA_WIDTH-1:0] op1_o,
  output logic [DATA_WIDTH-1:0] op2_o,
  output logic                  unsupported_o,
  output logic                  is_beq_o,
  output logic                  is_bne_o
);

  logic [5:0]            opcode_s;
  logic [5:0]            funct_s;
  logic [4:0]            shamt_s;
  logic [15:0]           imm_s;
  logic [DATA_WIDTH-1:0] imm_sext_s;
  logic [DATA_WIDTH-1:0] imm_zext_s;
  logic [DATA_WIDTH-1:0] shamt_zext_s;
  logic                  unused_fields_s;

  assign opcode_s     = instr_i[31:26];
  assign funct_s      = instr_i[5:0];
  assign shamt_s      = instr_i[10:6];
  assign imm_s        = instr_i[15:0];
  assign imm_sext_s   = {{(DATA_WIDTH-16){imm_s[15]}}, imm_s};
  assign imm_zext_s   = {{(DATA_WIDTH-16){1'b0}}, imm_s};
  assign shamt_zext_s = {{(DATA_WIDTH-5){1'b0}}, shamt_s};
  // Register-number fields are resolved upstream; only the operand values arrive here.
  assign unused_fields_s = ^instr_i[25:16];

  // Decode opcode/funct into operation code and operand selection
  always_comb begin
    oprn_o        = OPRN_WIDTH'(OPRN_NOP);
    op1_o         = rs_data_i;
    op2_o         = rt_data_i;
    unsupported_o = 1'b0;
    is_beq_o      = 1'b0;
    is_bne_o      = 1'b0;
    case (opcode_s)
      OPC_RTYPE: begin
        case (funct_s)
          FN_ADD:  oprn_o = OPRN_WIDTH'(OPRN_ADD);
          FN_SUB:  oprn_o = OPRN_WIDTH'(OPRN_SUB);
          FN_MUL:  oprn_o = OPRN_WIDTH'(OPRN_MUL);
          FN_SRL:  begin oprn_o = OPRN_WIDTH'(OPRN_SRL); op2_o = shamt_zext_s; end
          FN_SLL:  begin oprn_o = OPRN_WIDTH'(OPRN_SLL); op2_o = shamt_zext_s; end
          FN_AND:  oprn_o = OPRN_WIDTH'(OPRN_AND);
          FN_OR:   oprn_o = OPRN_WIDTH'(OPRN_OR);
          FN_NOR:  oprn_o = OPRN_WIDTH'(OPRN_NOR);
          FN_SLT:  oprn_o = OPRN_WIDTH'(OPRN_SLT);
          default: unsupported_o = 1'b1;
        endcase
      end
      OPC_ADDI: begin oprn_o = OPRN_WIDTH'(OPRN_ADD); op2_o = imm_sext_s; end
      OPC_MULI: begin oprn_o = OPRN_WIDTH'(OPRN_MUL); op2_o = imm_sext_s; end
      OPC_SLTI: begin oprn_o = OPRN_WIDTH'(OPRN_SLT); op2_o = imm_sext_s; end
      OPC_ANDI: begin oprn_o = OPRN_WIDTH'(OPRN_AND); op2_o = imm_zext_s; end
      OPC_ORI:  begin oprn_o = OPRN_WIDTH'(OPRN_OR);  op2_o = imm_zext_s; end
`ifdef ALU_ISSUE_BRANCH_EN
      OPC_BEQ:  begin oprn_o = OPRN_WIDTH'(OPRN_SUB); is_beq_o = 1'b1; end
      OPC_BNE:  begin oprn_o = OPRN_WIDTH'(OPRN_SUB); is_bne_o = 1'b1; end
`endif
      default:  unsupported_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_issue.sv
// Issue stage between decode/register-read and writeback: drives the external ALU for one cycle
// and offers its result downstream. ALU_ISSUE_BRANCH_EN (decoder) enables beq/bne and RES_TAKEN.
module alu_issue
  import alu_issue_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int OPRN_WIDTH = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  INSTR_VALID,
  output logic                  INSTR_READY,
  input  logic [31:0]           INSTR,
  input  logic [DATA_WIDTH-1:0] RS_DATA,
  input  logic [DATA_WIDTH-1:0] RT_DATA,
  output logic [DATA_WIDTH-1:0] ALU_OP1,
  output logic [DATA_WIDTH-1:0] ALU_OP2,
  output logic [OPRN_WIDTH-1:0] ALU_OPRN,
  input  logic [DATA_WIDTH-1:0] ALU_OUT,
  input  logic                  ALU_ZERO,
  output logic                  RES_VALID,
  input  logic                  RES_READY,
  output logic [DATA_WIDTH-1:0] RES_DATA,
  output logic                  RES_ZERO,
  output logic                  RES_ERR,
  output logic                  RES_TAKEN
);

  state_e                state_q, state_d;
  logic [OPRN_WIDTH-1:0] oprn_q, oprn_d;
  logic [DATA_WIDTH-1:0] op1_q, op1_d;
  logic [DATA_WIDTH-1:0] op2_q, op2_d;
  logic                  is_beq_q, is_beq_d;
  logic                  is_bne_q, is_bne_d;
  logic [DATA_WIDTH-1:0] res_data_q, res_data_d;
  logic                  res_zero_q, res_zero_d;
  logic                  res_err_q, res_err_d;
  logic                  res_taken_q, res_taken_d;

  logic [OPRN_WIDTH-1:0] dec_oprn_s;
  logic [DATA_WIDTH-1:0] dec_op1_s;
  logic [DATA_WIDTH-1:0] dec_op2_s;
  logic                  dec_unsup_s;
  logic                  dec_beq_s;
  logic                  dec_bne_s;
  logic                  instr_ready_s;
  logic                  xfer_s;

  alu_issue_decode #(
    .DATA_WIDTH (DATA_WIDTH),
    .OPRN_WIDTH (OPRN_WIDTH)
  ) u_decode (
    .instr_i       (INSTR),
    .rs_data_i     (RS_DATA),
    .rt_data_i     (RT_DATA),
    .oprn_o        (dec_oprn_s),
    .op1_o         (dec_op1_s),
    .op2_o         (dec_op2_s),
    .unsupported_o (dec_unsup_s),
    .is_beq_o      (dec_beq_s),
    .is_bne_o      (dec_bne_s)
  );

  // Ready is masked by RST so nothing is accepted while the block is held in reset.
  assign instr_ready_s = RST & ((state_q == ST_IDLE) | ((state_q == ST_DONE) & RES_READY));
  assign xfer_s        = INSTR_VALID & instr_ready_s;

  // Next-state and register-load logic
  always_comb begin
    state_d     = state_q;
    oprn_d      = oprn_q;
    op1_d       = op1_q;
    op2_d       = op2_q;
    is_beq_d    = is_beq_q;
    is_bne_d    = is_bne_q;
    res_data_d  = res_data_q;
    res_zero_d  = res_zero_q;
    res_err_d   = res_err_q;
    res_taken_d = res_taken_q;

    case (state_q)
      ST_IDLE: begin
        if (xfer_s) begin
          state_d = dec_unsup_s ? ST_DONE : ST_EXEC;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_EXEC: state_d = ST_DONE;
      ST_DONE: begin
        if (xfer_s) begin
          state_d = dec_unsup_s ? ST_DONE : ST_EXEC;
        end else if (RES_READY) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Unsupported instructions leave the ALU-side registers untouched.
    if (xfer_s & ~dec_unsup_s) begin
      oprn_d   = dec_oprn_s;
      op1_d    = dec_op1_s;
      op2_d    = dec_op2_s;
      is_beq_d = dec_beq_s;
      is_bne_d = dec_bne_s;
    end else begin
      oprn_d   = oprn_q;
      op1_d    = op1_q;
      op2_d    = op2_q;
      is_beq_d = is_beq_q;
      is_bne_d = is_bne_q;
    end

    if (state_q == ST_EXEC) begin
      res_data_d  = ALU_OUT;
      res_zero_d  = ALU_ZERO;
      res_err_d   = 1'b0;
      res_taken_d = (is_beq_q & ALU_ZERO) | (is_bne_q & ~ALU_ZERO);
    end else if (xfer_s & dec_unsup_s) begin
      res_data_d  = {DATA_WIDTH{1'b0}};
      res_zero_d  = 1'b0;
      res_err_d   = 1'b1;
      res_taken_d = 1'b0;
    end else begin
      res_data_d  = res_data_q;
      res_zero_d  = res_zero_q;
      res_err_d   = res_err_q;
      res_taken_d = res_taken_q;
    end
  end

  // State and datapath registers
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= ST_IDLE;
      oprn_q      <= {OPRN_WIDTH{1'b0}};
      op1_q       <= {DATA_WIDTH{1'b0}};
      op2_q       <= {DATA_WIDTH{1'b0}};
      is_beq_q    <= 1'b0;
      is_bne_q    <= 1'b0;
      res_data_q  <= {DATA_WIDTH{1'b0}};
      res_zero_q  <= 1'b0;
      res_err_q   <= 1'b0;
      res_taken_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      oprn_q      <= oprn_d;
      op1_q       <= op1_d;
      op2_q       <= op2_d;
      is_beq_q    <= is_beq_d;
      is_bne_q    <= is_bne_d;
      res_data_q  <= res_data_d;
      res_zero_q  <= res_zero_d;
      res_err_q   <= res_err_d;
      res_taken_q <= res_taken_d;
    end
  end

  assign INSTR_READY = instr_ready_s;
  assign RES_VALID   = (state_q == ST_DONE);
  assign ALU_OPRN    = oprn_q;
  assign ALU_OP1     = op1_q;
  assign ALU_OP2     = op2_q;
  assign RES_DATA    = res_data_q;
  assign RES_ZERO    = res_zero_q;
  assign RES_ERR     = res_err_q;
  assign RES_TAKEN   = res_taken_q;

endmodule

// File: tb/tb_alu_issue.sv
// Scoreboard bench for alu_issue with a behavioural ALU attached to the ALU_* ports.
module tb_alu_issue;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        INSTR_VALID = 1'b0;
  logic        INSTR_READY;
  logic [31:0] INSTR = 32'd0;
  logic [31:0] RS_DATA = 32'd0;
  logic [31:0] RT_DATA = 32'd0;
  logic [31:0] ALU_OP1, ALU_OP2, ALU_OUT;
  logic [5:0]  ALU_OPRN;
  logic        ALU_ZERO;
  logic        RES_VALID;
  logic        RES_READY = 1'b0;
  logic [31:0] RES_DATA;
  logic        RES_ZERO, RES_ERR, RES_TAKEN;

  typedef struct packed {
    logic [5:0]  oprn;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] data;
    logic        zero;
    logic        err;
    logic        taken;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  bit          rand_ready = 1'b0;
  logic [5:0]  last_oprn = 6'd0;
  logic [31:0] last_op1 = 32'd0;
  logic [31:0] last_op2 = 32'd0;

  alu_issue #(.DATA_WIDTH(32), .OPRN_WIDTH(6)) dut (
    .CLK(CLK), .RST(RST), .INSTR_VALID(INSTR_VALID), .INSTR_READY(INSTR_READY),
    .INSTR(INSTR), .RS_DATA(RS_DATA), .RT_DATA(RT_DATA),
    .ALU_OP1(ALU_OP1), .ALU_OP2(ALU_OP2), .ALU_OPRN(ALU_OPRN),
    .ALU_OUT(ALU_OUT), .ALU_ZERO(ALU_ZERO),
    .RES_VALID(RES_VALID), .RES_READY(RES_READY), .RES_DATA(RES_DATA),
    .RES_ZERO(RES_ZERO), .RES_ERR(RES_ERR), .RES_TAKEN(RES_TAKEN)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  function automatic logic [31:0] alu_f(input logic [5:0] oprn, input logic [31:0] a, input logic [31:0] b);
    case (oprn)
      6'h01:   return a + b;
      6'h02:   return a - b;
      6'h03:   return a * b;
      6'h04:   return a >> b;
      6'h05:   return a << b;
      6'h06:   return a & b;
      6'h07:   return a | b;
      6'h08:   return ~(a | b);
      6'h09:   return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  assign ALU_OUT  = alu_f(ALU_OPRN, ALU_OP1, ALU_OP2);
  assign ALU_ZERO = (ALU_OUT == 32'd0);

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [31:0] instr, input logic [31:0] rs, input logic [31:0] rt);
    exp_t        e;
    logic [15:0] imm;
    logic [31:0] se, ze;
    logic        beq, bne;
    imm = instr[15:0];
    se  = {{16{imm[15]}}, imm};
    ze  = {16'h0000, imm};
    beq = 1'b0;
    bne = 1'b0;
    e   = '0;
    e.op1 = rs;
    e.op2 = rt;
    case (instr[31:26])
      6'h00: begin
        case (instr[5:0])
          6'h20: e.oprn = 6'h01;
          6'h22: e.oprn = 6'h02;
          6'h2c: e.oprn = 6'h03;
          6'h02: begin e.oprn = 6'h04; e.op2 = {27'd0, instr[10:6]}; end
          6'h01: begin e.oprn = 6'h05; e.op2 = {27'd0, instr[10:6]}; end
          6'h24: e.oprn = 6'h06;
          6'h25: e.oprn = 6'h07;
          6'h27: e.oprn = 6'h08;
          6'h2a: e.oprn = 6'h09;
          default: e.err = 1'b1;
        endcase
      end
      6'h08: begin e.oprn = 6'h01; e.op2 = se; end
      6'h1d: begin e.oprn = 6'h03; e.op2 = se; end
      6'h0a: begin e.oprn = 6'h09; e.op2 = se; end
      6'h0c: begin e.oprn = 6'h06; e.op2 = ze; end
      6'h0d: begin e.oprn = 6'h07; e.op2 = ze; end
`ifdef ALU_ISSUE_BRANCH_EN
      6'h04: begin e.oprn = 6'h02; beq = 1'b1; end
      6'h05: begin e.oprn = 6'h02; bne = 1'b1; end
`endif
      default: e.err = 1'b1;
    endcase
    if (e.err) begin
      e.oprn = last_oprn;
      e.op1  = last_op1;
      e.op2  = last_op2;
    end else begin
      e.data  = alu_f(e.oprn, e.op1, e.op2);
      e.zero  = (e.data == 32'd0);
      e.taken = (beq & e.zero) | (bne & ~e.zero);
    end
    return e;
  endfunction

  // Scoreboard monitor: compare each result at the cycle it is handed downstream.
  always begin
    exp_t e;
    @(negedge CLK);
    #1;
    if (RST && RES_VALID && RES_READY) begin
      chk("sb_nonempty", sb_q.size() != 0, 1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        chk("res_data", RES_DATA, e.data);
        chk("res_zero", RES_ZERO, e.zero);
        chk("res_err", RES_ERR, e.err);
        chk("res_taken", RES_TAKEN, e.taken);
        chk("alu_oprn", ALU_OPRN, e.oprn);
        chk("alu_op1", ALU_OP1, e.op1);
        chk("alu_op2", ALU_OP2, e.op2);
      end
    end
  end

  always @(negedge CLK) begin
    if (rand_ready) RES_READY = ($urandom_range(0, 2) != 0);
  end

  task automatic send(input logic [31:0] instr, input logic [31:0] rs, input logic [31:0] rt);
    exp_t e;
    INSTR = instr;
    RS_DATA = rs;
    RT_DATA = rt;
    INSTR_VALID = 1'b1;
    #1;
    for (int i = 0; i < 40 && !INSTR_READY; i++) begin
      @(negedge CLK);
      #1;
    end
    chk("instr_ready", INSTR_READY, 1);
    e = model(instr, rs, rt);
    sb_q.push_back(e);
    if (!e.err) begin
      last_oprn = e.oprn;
      last_op1  = e.op1;
      last_op2  = e.op2;
    end
    @(negedge CLK);
    INSTR_VALID = 1'b0;
  endtask

  task automatic wait_drain();
    @(negedge CLK);
    RES_READY = 1'b1;
    for (int i = 0; i < 60 && sb_q.size() != 0; i++) begin
      @(negedge CLK);
      #2;
    end
    chk("drain", sb_q.size(), 0);
    @(negedge CLK);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [5:0]  fn_tab [9];
    logic [5:0]  op_tab [5];
    logic [31:0] w;
    int          sel;
    fn_tab = '{6'h20, 6'h22, 6'h2c, 6'h02, 6'h01, 6'h24, 6'h25, 6'h27, 6'h2a};
    op_tab = '{6'h08, 6'h1d, 6'h0a, 6'h0c, 6'h0d};
    sel = $urandom_range(0, 15);
    w = $urandom();
    if (sel < 9) begin
      w[31:26] = 6'h00;
      w[5:0]   = fn_tab[sel];
    end else if (sel < 14) begin
      w[31:26] = op_tab[sel-9];
    end else if (sel == 14) begin
      w[31:26] = ($urandom_range(0, 1) != 0) ? 6'h04 : 6'h05;
    end else begin
      w[31:26] = 6'h00;
      w[5:0]   = 6'h3f;
    end
    return w;
  endfunction

  initial begin
    logic [31:0] rs, rt;
    int t0;
    repeat (3) @(negedge CLK);
    chk("rst_instr_ready", INSTR_READY, 0);
    chk("rst_res_valid", RES_VALID, 0);
    chk("rst_res_data", RES_DATA, 0);
    chk("rst_res_flags", {RES_ZERO, RES_ERR, RES_TAKEN}, 0);
    chk("rst_alu_oprn", ALU_OPRN, 0);
    chk("rst_alu_ops", {ALU_OP1, ALU_OP2}, 0);
    RST = 1'b1;
    #1;
    chk("idle_instr_ready", INSTR_READY, 1);
    @(negedge CLK);

    // add, then one-cycle latency to RES_VALID
    RES_READY = 1'b1;
    send(32'h0000_0020, 32'd5, 32'd7);
    chk("add_oprn", ALU_OPRN, 6'h01);
    chk("add_ops", {ALU_OP1, ALU_OP2}, {32'd5, 32'd7});
    chk("add_lat0", RES_VALID, 0);
    @(negedge CLK);
    chk("add_lat1", RES_VALID, 1);
    chk("add_data", RES_DATA, 32'd12);
    chk("add_zero", RES_ZERO, 0);

    // addi with negative imm followed back-to-back by andi
    send(32'h2000_FFFD, 32'd3, 32'd0);
    t0 = cyc;
    chk("addi_op2", ALU_OP2, 32'hFFFF_FFFD);
    send(32'h3000_FFFD, 32'd3, 32'd0);
    chk("b2b_cycles", cyc - t0, 2);
    chk("andi_op2", ALU_OP2, 32'h0000_FFFD);
    @(negedge CLK);
    chk("andi_valid", RES_VALID, 1);
    chk("andi_data", RES_DATA, 32'd1);

    // sll by shamt
    send(32'h0000_0101, 32'd1, 32'd0);
    chk("sll_oprn", ALU_OPRN, 6'h05);
    chk("sll_op2", ALU_OP2, 32'd4);
    @(negedge CLK);
    chk("sll_data", RES_DATA, 32'd16);
    wait_drain();

    // downstream stall holds everything
    RES_READY = 1'b0;
    send(32'h0000_0020, 32'd10, 32'd20);
    @(negedge CLK);
    for (int i = 0; i < 3; i++) begin
      chk("stall_valid", RES_VALID, 1);
      chk("stall_data", RES_DATA, 32'd30);
      chk("stall_ready", INSTR_READY, 0);
      chk("stall_op1", ALU_OP1, 32'd10);
      @(negedge CLK);
    end

    // unsupported opcode: done after one edge, ALU side untouched
    RES_READY = 1'b1;
    send(32'hFC00_0000, 32'd1, 32'd2);
    chk("err_valid", RES_VALID, 1);
    chk("err_flag", RES_ERR, 1);
    chk("err_data", RES_DATA, 0);
    chk("err_alu", {ALU_OPRN, ALU_OP1, ALU_OP2}, {6'h01, 32'd10, 32'd20});
    wait_drain();

    // branches
    send(32'h1022_0010, 32'd9, 32'd9);
    @(negedge CLK);
`ifdef ALU_ISSUE_BRANCH_EN
    chk("beq_taken", RES_TAKEN, 1);
`else
    chk("beq_err", RES_ERR, 1);
`endif
    send(32'h1422_0010, 32'd9, 32'd9);
    @(negedge CLK);
`ifdef ALU_ISSUE_BRANCH_EN
    chk("bne_taken", RES_TAKEN, 0);
`else
    chk("bne_err", RES_ERR, 1);
`endif
    wait_drain();

    // reset during EXEC discards the pending result
    send(32'h0000_0022, 32'd50, 32'd8);
    RST = 1'b0;
    #1;
    chk("rst_exec_valid", RES_VALID, 0);
    chk("rst_exec_oprn", ALU_OPRN, 0);
    chk("rst_exec_ready", INSTR_READY, 0);
    sb_q.delete();
    last_oprn = 6'd0;
    last_op1 = 32'd0;
    last_op2 = 32'd0;
    @(negedge CLK);
    RST = 1'b1;
    send(32'h0000_0025, 32'h0000_00F0, 32'h0000_000F);
    @(negedge CLK);
    chk("post_rst_valid", RES_VALID, 1);
    chk("post_rst_data", RES_DATA, 32'h0000_00FF);
    wait_drain();

    // random mix with random downstream backpressure
    rand_ready = 1'b1;
    for (int n = 0; n < 40; n++) begin
      rs = $urandom();
      rt = ($urandom_range(0, 3) == 0) ? rs : $urandom();
      send(rand_instr(), rs, rt);
    end
    rand_ready = 1'b0;
    wait_drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
